// File: rtl/adc_sar_logic_param.sv
// Parametrised SAR conversion controller: conventional or monotonic switching per conversion.
// Optional comparator consistency check enabled by defining SAR_COMP_CHECK_EN (adds comp_err).
module adc_sar_logic_param #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             samp,
    input  logic             mode,
    input  logic             comp,
    input  logic             comp_n,
    output logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] BN,
    output logic [WIDTH-1:0] result,
    output logic             eoc,
`ifdef SAR_COMP_CHECK_EN
    output logic             comp_err,
`endif
    output logic             busy
);

    localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] ONES    = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MSB_ONE = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [IW-1:0]    IDX_TOP = IW'(WIDTH-1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_CONV   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t           state_r;
    logic             mode_r;
    logic [IW-1:0]    idx_r;
    logic [WIDTH-1:0] code_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] bn_r;
    logic [WIDTH-1:0] result_r;
    logic             eoc_r;
    logic             busy_r;
    logic             dec_s;
    logic             fault_s;
    logic [WIDTH-1:0] conv_b_s;
    logic [WIDTH-1:0] mono_b_s;
    logic [WIDTH-1:0] mono_bn_s;
    logic [WIDTH-1:0] code_next_s;

`ifdef SAR_COMP_CHECK_EN
    logic             err_r;
    assign comp_err = err_r;
`endif

    assign B      = b_r;
    assign BN     = bn_r;
    assign result = result_r;
    assign eoc    = eoc_r;
    assign busy   = busy_r;

    // Bit decision, with a stuck/equal comparator pair forced to a 0 decision when checked.
    always_comb begin
        fault_s = (comp == comp_n);
`ifdef SAR_COMP_CHECK_EN
        if (fault_s) begin
            dec_s = 1'b0;
        end else begin
            dec_s = comp;
        end
`else
        // comp_n carries no information without the checker
        dec_s = comp & (comp_n | 1'b1);
`endif
    end

    // Next DAC codes for the bit currently being resolved.
    always_comb begin
        conv_b_s    = b_r;
        mono_b_s    = b_r;
        mono_bn_s   = bn_r;
        code_next_s = {code_r[WIDTH-2:0], dec_s};
        for (int i = 0; i < WIDTH; i++) begin
            if (i == int'(idx_r)) begin
                conv_b_s[i] = dec_s;
                if (dec_s) begin
                    mono_b_s[i] = 1'b0;
                end else begin
                    mono_bn_s[i] = 1'b0;
                end
            end else if (i + 1 == int'(idx_r)) begin
                conv_b_s[i] = 1'b1;
            end else begin
                conv_b_s[i] = b_r[i];
            end
        end
    end

    // Conversion state machine with registered DAC drive, result, eoc and busy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            mode_r   <= 1'b0;
            idx_r    <= '0;
            code_r   <= '0;
            b_r      <= '0;
            bn_r     <= ONES;
            result_r <= '0;
            eoc_r    <= 1'b0;
            busy_r   <= 1'b0;
`ifdef SAR_COMP_CHECK_EN
            err_r    <= 1'b0;
`endif
        end else begin
            eoc_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    b_r    <= '0;
                    bn_r   <= ONES;
                    busy_r <= 1'b0;
                    if (samp) begin
                        state_r <= ST_SAMPLE;
`ifdef SAR_COMP_CHECK_EN
                        err_r   <= 1'b0;
`endif
                    end
                end
                ST_SAMPLE: begin
                    if (!samp) begin
                        state_r <= ST_CONV;
                        mode_r  <= mode;
                        idx_r   <= IDX_TOP;
                        code_r  <= '0;
                        busy_r  <= 1'b1;
                        if (mode) begin
                            b_r  <= ONES;
                            bn_r <= ONES;
                        end else begin
                            b_r  <= MSB_ONE;
                            bn_r <= ~MSB_ONE;
                        end
                    end else begin
                        b_r  <= '0;
                        bn_r <= ONES;
                    end
                end
                ST_CONV: begin
                    if (samp) begin
                        // resample aborts: drop the partial code, no eoc
                        state_r <= ST_SAMPLE;
                        b_r     <= '0;
                        bn_r    <= ONES;
                        busy_r  <= 1'b0;
`ifdef SAR_COMP_CHECK_EN
                        err_r   <= 1'b0;
`endif
                    end else begin
                        code_r <= code_next_s;
                        if (mode_r) begin
                            b_r  <= mono_b_s;
                            bn_r <= mono_bn_s;
                        end else begin
                            b_r  <= conv_b_s;
                            bn_r <= ~conv_b_s;
                        end
`ifdef SAR_COMP_CHECK_EN
                        if (fault_s) begin
                            err_r <= 1'b1;
                        end
`endif
                        if (idx_r == '0) begin
                            state_r  <= ST_DONE;
                            result_r <= code_next_s;
                            eoc_r    <= 1'b1;
                            busy_r   <= 1'b0;
                        end else begin
                            idx_r <= idx_r - IW'(1);
                        end
                    end
                end
                ST_DONE: begin
                    b_r    <= '0;
                    bn_r   <= ONES;
                    busy_r <= 1'b0;
                    if (samp) begin
                        state_r <= ST_SAMPLE;
`ifdef SAR_COMP_CHECK_EN
                        err_r   <= 1'b0;
`endif
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    b_r     <= '0;
                    bn_r    <= ONES;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_sar_logic_param.sv
// Self-checking bench for adc_sar_logic_param (WIDTH=10 and WIDTH=4 instances).
// Expected DAC codes come from binary-search arithmetic on a random target value.
module tb_adc_sar_logic_param;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       samp = 1'b0, mode = 1'b0, comp = 1'b0, comp_n = 1'b1;
    logic [9:0] b10, bn10, result10;
    logic       eoc10, busy10, err10;
    logic       samp4 = 1'b0, mode4 = 1'b0, comp4 = 1'b0, comp_n4 = 1'b1;
    logic [3:0] b4, bn4, result4;
    logic       eoc4, busy4, err4;

    int errors = 0;
    int checks = 0;

    logic [9:0] ob_b [10];
    logic [9:0] ob_bn[10];
    logic       ob_busy[10], ob_eoc[10], ob_err[10];
    logic [9:0] done_result, done_b, done_bn, post_b, post_bn, ab_b, ab_bn;
    logic       done_eoc, done_busy, done_err, post_eoc, post_busy, post_err;
    logic       ab_busy, abort_eoc_seen;

    always #5 clk = ~clk;

    adc_sar_logic_param #(.WIDTH(10)) dut10 (
        .clk(clk), .rst_n(rst_n), .samp(samp), .mode(mode), .comp(comp), .comp_n(comp_n),
        .B(b10), .BN(bn10), .result(result10), .eoc(eoc10),
`ifdef SAR_COMP_CHECK_EN
        .comp_err(err10),
`endif
        .busy(busy10)
    );

    adc_sar_logic_param #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .samp(samp4), .mode(mode4), .comp(comp4), .comp_n(comp_n4),
        .B(b4), .BN(bn4), .result(result4), .eoc(eoc4),
`ifdef SAR_COMP_CHECK_EN
        .comp_err(err4),
`endif
        .busy(busy4)
    );

`ifndef SAR_COMP_CHECK_EN
    assign err10 = 1'b0;
    assign err4  = 1'b0;
`endif

    // Drives one WIDTH=10 conversion; comp answers come from the target, outputs are recorded.
    task automatic conv10(input logic [9:0] target, input logic m, input bit start_idle,
                          input int abort_at, input int fault_at, input bit samp_hi_done);
        logic [9:0] code;
        logic [9:0] trial;
        int bi;
        code = 10'd0;
        if (start_idle) begin
            @(negedge clk);
            samp = 1'b1; comp = 1'b0; comp_n = 1'b1;
            @(negedge clk);
        end
        samp = 1'b0;
        mode = m;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            ob_b[k] = b10; ob_bn[k] = bn10; ob_busy[k] = busy10;
            ob_eoc[k] = eoc10; ob_err[k] = err10;
            if (k == abort_at) begin
                samp = 1'b1;
                @(negedge clk);
                ab_b = b10; ab_bn = bn10; ab_busy = busy10; abort_eoc_seen = eoc10;
                repeat (12) begin
                    @(negedge clk);
                    abort_eoc_seen = abort_eoc_seen | eoc10;
                end
                return;
            end
            bi = 9 - k;
            trial = code | (10'd1 << bi);
            if (m) comp = target[bi];
            else   comp = (trial <= target);
            comp_n = ~comp;
            if (k == fault_at) begin
                comp = 1'b1; comp_n = 1'b1;
            end else if (comp) begin
                code = trial;
            end
            mode = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        done_eoc = eoc10; done_result = result10; done_busy = busy10;
        done_b = b10; done_bn = bn10; done_err = err10;
        samp = samp_hi_done; comp = 1'b0; comp_n = 1'b1;
        @(negedge clk);
        post_eoc = eoc10; post_busy = busy10; post_b = b10; post_bn = bn10; post_err = err10;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (b10 !== 10'h000) begin errors++; $display("FAIL reset_B got=%h exp=000", b10); end
        checks++; if (bn10 !== 10'h3FF) begin errors++; $display("FAIL reset_BN got=%h exp=3ff", bn10); end
        checks++; if (result10 !== 10'h000) begin errors++; $display("FAIL reset_result got=%h exp=000", result10); end
        checks++; if ({eoc10, busy10, err10} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {eoc10, busy10, err10}); end
        checks++; if ({b4, bn4} !== 8'h0F) begin errors++; $display("FAIL reset_w4 got=%h exp=0f", {b4, bn4}); end
        rst_n = 1'b1;
    endtask

    task automatic test_conventional();
        logic [9:0] t, up, exp_b;
        for (int n = 0; n < 4; n++) begin
            t = (n == 0) ? 10'h2A5 : 10'($urandom);
            conv10(t, 1'b0, 1'b1, -1, -1, 1'b0);
            for (int k = 0; k < 10; k++) begin
                up = 10'h3FF << (10 - k);
                exp_b = (t & up) | (10'd1 << (9 - k));
                checks++; if (ob_b[k] !== exp_b) begin errors++; $display("FAIL conv_B step=%0d got=%h exp=%h", k, ob_b[k], exp_b); end
                checks++; if (ob_bn[k] !== ~exp_b) begin errors++; $display("FAIL conv_BN step=%0d got=%h exp=%h", k, ob_bn[k], ~exp_b); end
                checks++; if ({ob_busy[k], ob_eoc[k]} !== 2'b10) begin errors++; $display("FAIL conv_busy_eoc step=%0d got=%b exp=10", k, {ob_busy[k], ob_eoc[k]}); end
            end
            checks++; if ({done_eoc, done_busy} !== 2'b10) begin errors++; $display("FAIL conv_done_flags got=%b exp=10", {done_eoc, done_busy}); end
            checks++; if (done_result !== t) begin errors++; $display("FAIL conv_result got=%h exp=%h", done_result, t); end
            checks++; if ({done_b, done_bn} !== {t, ~t}) begin errors++; $display("FAIL conv_final_dac got=%h/%h exp=%h/%h", done_b, done_bn, t, ~t); end
            checks++; if ({post_eoc, post_busy, post_b, post_bn} !== {2'b00, 10'h000, 10'h3FF}) begin errors++; $display("FAIL conv_post got=%b %h %h", {post_eoc, post_busy}, post_b, post_bn); end
            checks++; if (result10 !== t) begin errors++; $display("FAIL conv_result_hold got=%h exp=%h", result10, t); end
        end
    endtask

    task automatic test_monotonic();
        logic [9:0] t, up, exp_b, exp_bn;
        for (int n = 0; n < 4; n++) begin
            t = (n == 0) ? 10'h15A : 10'($urandom);
            conv10(t, 1'b1, 1'b1, -1, -1, 1'b0);
            for (int k = 0; k < 10; k++) begin
                up = 10'h3FF << (10 - k);
                exp_b  = ~(t & up);
                exp_bn = ~(~t & up);
                checks++; if ({ob_b[k], ob_bn[k]} !== {exp_b, exp_bn}) begin errors++; $display("FAIL mono_dac step=%0d got=%h/%h exp=%h/%h", k, ob_b[k], ob_bn[k], exp_b, exp_bn); end
                checks++; if ({ob_busy[k], ob_eoc[k]} !== 2'b10) begin errors++; $display("FAIL mono_busy_eoc step=%0d got=%b exp=10", k, {ob_busy[k], ob_eoc[k]}); end
            end
            checks++; if ({done_eoc, done_result} !== {1'b1, t}) begin errors++; $display("FAIL mono_result got=%b %h exp=1 %h", done_eoc, done_result, t); end
            checks++; if ({done_b, done_bn} !== {~t, t}) begin errors++; $display("FAIL mono_final_dac got=%h/%h exp=%h/%h", done_b, done_bn, ~t, t); end
            checks++; if ({post_eoc, post_b, post_bn} !== {1'b0, 10'h000, 10'h3FF}) begin errors++; $display("FAIL mono_post got=%b %h %h", post_eoc, post_b, post_bn); end
        end
    endtask

    task automatic test_abort();
        logic [9:0] t1, t2, t3;
        logic m;
        t1 = 10'($urandom); t2 = ~t1; t3 = 10'($urandom);
        m = 1'($urandom_range(0, 1));
        conv10(t1, m, 1'b1, -1, -1, 1'b0);
        checks++; if (done_result !== t1) begin errors++; $display("FAIL abort_pre_result got=%h exp=%h", done_result, t1); end
        conv10(t2, ~m, 1'b1, 5, -1, 1'b0);
        checks++; if (ob_busy[5] !== 1'b1) begin errors++; $display("FAIL abort_busy_before got=%b exp=1", ob_busy[5]); end
        checks++; if ({ab_busy, ab_b, ab_bn} !== {1'b0, 10'h000, 10'h3FF}) begin errors++; $display("FAIL abort_sample got=%b %h %h exp=0 000 3ff", ab_busy, ab_b, ab_bn); end
        checks++; if (abort_eoc_seen !== 1'b0) begin errors++; $display("FAIL abort_no_eoc got=%b exp=0", abort_eoc_seen); end
        checks++; if (result10 !== t1) begin errors++; $display("FAIL abort_result_kept got=%h exp=%h", result10, t1); end
        conv10(t3, m, 1'b0, -1, -1, 1'b0);
        checks++; if ({done_eoc, done_result} !== {1'b1, t3}) begin errors++; $display("FAIL abort_next_conv got=%b %h exp=1 %h", done_eoc, done_result, t3); end
    endtask

    task automatic test_back_to_back();
        logic [9:0] t1, t2;
        t1 = 10'($urandom); t2 = 10'($urandom);
        conv10(t1, 1'b0, 1'b1, -1, -1, 1'b1);
        checks++; if ({done_eoc, done_result} !== {1'b1, t1}) begin errors++; $display("FAIL b2b_first got=%b %h exp=1 %h", done_eoc, done_result, t1); end
        checks++; if ({post_eoc, post_busy, post_b, post_bn} !== {2'b00, 10'h000, 10'h3FF}) begin errors++; $display("FAIL b2b_sample_outputs got=%b %h %h", {post_eoc, post_busy}, post_b, post_bn); end
        conv10(t2, 1'b1, 1'b0, -1, -1, 1'b0);
        checks++; if (ob_busy[0] !== 1'b1) begin errors++; $display("FAIL b2b_no_idle busy got=%b exp=1", ob_busy[0]); end
        checks++; if ({done_eoc, done_result} !== {1'b1, t2}) begin errors++; $display("FAIL b2b_second got=%b %h exp=1 %h", done_eoc, done_result, t2); end
    endtask

    task automatic test_width4();
        logic [3:0] t, code, trial, up, exp_b;
        int bi;
        for (int m = 0; m < 2; m++) begin
            t = 4'($urandom); code = 4'd0;
            @(negedge clk); samp4 = 1'b1;
            @(negedge clk); samp4 = 1'b0; mode4 = 1'(m);
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                bi = 3 - k;
                up = 4'hF << (4 - k);
                exp_b = (m == 0) ? ((t & up) | (4'd1 << bi)) : ~(t & up);
                checks++; if ({eoc4, busy4, b4} !== {2'b01, exp_b}) begin errors++; $display("FAIL w4_step m=%0d k=%0d got=%b %h exp=01 %h", m, k, {eoc4, busy4}, b4, exp_b); end
                trial = code | (4'd1 << bi);
                comp4 = (m == 1) ? t[bi] : (trial <= t);
                comp_n4 = ~comp4;
                if (comp4) code = trial;
            end
            @(negedge clk);
            checks++; if ({eoc4, result4} !== {1'b1, t}) begin errors++; $display("FAIL w4_result m=%0d got=%b %h exp=1 %h", m, eoc4, result4, t); end
            comp4 = 1'b0; comp_n4 = 1'b1;
            @(negedge clk);
            checks++; if (eoc4 !== 1'b0) begin errors++; $display("FAIL w4_eoc_pulse got=%b exp=0", eoc4); end
        end
    endtask

`ifdef SAR_COMP_CHECK_EN
    task automatic test_comp_check();
        logic [9:0] t, exp_code;
        t = 10'($urandom) | 10'h040;
        exp_code = t & ~10'h040;
        conv10(t, 1'b1, 1'b1, -1, 3, 1'b1);
        for (int k = 0; k < 10; k++) begin
            checks++; if (ob_err[k] !== (k >= 4)) begin errors++; $display("FAIL cerr_step k=%0d got=%b exp=%b", k, ob_err[k], (k >= 4)); end
        end
        checks++; if ({done_err, done_result, done_bn} !== {1'b1, exp_code, exp_code}) begin errors++; $display("FAIL cerr_done got=%b %h %h exp=1 %h", done_err, done_result, done_bn, exp_code); end
        checks++; if (post_err !== 1'b0) begin errors++; $display("FAIL cerr_clear got=%b exp=0", post_err); end
    endtask
`endif

    task automatic test_reset_mid();
        logic seen;
        @(negedge clk); samp = 1'b1;
        @(negedge clk); samp = 1'b0; mode = 1'b0;
        repeat (5) begin
            @(negedge clk); comp = 1'($urandom_range(0, 1)); comp_n = ~comp;
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if ({eoc10, busy10, b10, bn10, result10} !== {2'b00, 10'h000, 10'h3FF, 10'h000}) begin errors++; $display("FAIL rst_mid got=%b %h %h %h", {eoc10, busy10}, b10, bn10, result10); end
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk); seen = seen | eoc10 | busy10;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_mid_no_eoc got=%b exp=0", seen); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_conventional();
        test_monotonic();
        test_abort();
        test_back_to_back();
        test_width4();
`ifdef SAR_COMP_CHECK_EN
        test_comp_check();
`endif
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
